// File: rtl/kbd_pkg.sv
// Shared types for the BK keyboard key-event scheduler: FIFO entry layout,
// FSM state encodings and the delivery handshake timeout.
package kbd_pkg;

  typedef struct packed {
    logic       vec274;
    logic [6:0] code;
  } kbd_entry_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DELAY,
    R_REPEAT
  } rep_state_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_LOAD,
    D_WAIT
  } dlv_state_t;

  // Cycles D_WAIT lingers when the register side never raises its ready flag.
  localparam int unsigned WAIT_LIMIT = 4;

  typedef struct packed {
    rep_state_t rep;
    dlv_state_t dlv;
  } kbd_dbg_t;

endpackage

// File: rtl/kbd_fifo.sv
// Small key-code FIFO: synchronous write, combinational head, registered
// occupancy. Full/empty come from the count held at the start of the cycle.
module kbd_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_bus,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  kbd_entry_t             din,
  input  logic                   pop,
  output kbd_entry_t             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  kbd_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_bus) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_bus or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kbd_key_sched.sv
// Key-event scheduler: queues translator key presses, generates typematic
// repeat for the held key and paces loads into the BK keyboard data register.
module kbd_key_sched
  import kbd_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int TICK_DIV  = 24000,
  parameter int REP_DELAY = 500,
  parameter int REP_RATE  = 50
) (
  input  logic                   clk_bus,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   evt_valid,
  input  logic                   evt_press,
  input  logic [6:0]             evt_code,
  input  logic                   evt_vec274,
  output logic                   evt_ready,
  input  logic                   repeat_en,
  input  logic                   kreg_busy,
  output logic                   kreg_load,
  output logic [6:0]             kreg_code,
  output logic                   kreg_vec274,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output kbd_dbg_t               dbg
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [15:0] DELAY_T = 16'(REP_DELAY);
  localparam logic [15:0] RATE_T  = 16'(REP_RATE);
  localparam int WCW = $clog2(WAIT_LIMIT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LIMIT - 1);

  // Handshake: evt_valid is a one-cycle strobe. A press is taken when
  // evt_valid && evt_ready; a break is consumed whatever evt_ready says.
  logic       is_press;
  logic       ext_push;
  logic       is_break_held;
  logic       rep_push;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  kbd_entry_t fifo_din;
  kbd_entry_t fifo_head;

  logic [PW-1:0] pre_cnt;
  logic          tick;

  rep_state_t rep_state, rep_next;
  logic [15:0] timer, timer_next;
  kbd_entry_t  held, held_next;

  dlv_state_t     dlv_state, dlv_next;
  logic [WCW-1:0] wait_cnt, wait_next;
  logic           latch_head;

  assign is_press      = evt_valid && evt_press && (evt_code != 7'd0);
  assign ext_push      = is_press && !fifo_full;
  assign is_break_held = evt_valid && !evt_press && (evt_code == held.code);
  assign evt_ready     = !fifo_full;
  assign dbg           = '{rep: rep_state, dlv: dlv_state};

  assign fifo_push = ext_push || rep_push;
  assign fifo_din  = ext_push ? kbd_entry_t'({evt_vec274, evt_code}) : held;

  kbd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_bus (clk_bus),
    .reset_n (reset_n),
    .clear   (flush),
    .push    (fifo_push),
    .din     (fifo_din),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign tick = (pre_cnt == '0);

  always_ff @(posedge clk_bus or negedge reset_n) begin
    if (!reset_n)                     pre_cnt <= PRE_MAX;
    else if (flush || pre_cnt == '0)  pre_cnt <= PRE_MAX;
    else                              pre_cnt <= pre_cnt - PW'(1);
  end

  always_ff @(posedge clk_bus or negedge reset_n) begin
    if (!reset_n)                       overflow <= 1'b0;
    else if (flush)                     overflow <= 1'b0;
    else if (is_press && fifo_full)     overflow <= 1'b1;
  end

  // A new press always wins over the running countdown, so a second key
  // takes over the repeat. Repeats only go into an empty FIFO.
  always_comb begin
    rep_next   = rep_state;
    timer_next = timer;
    held_next  = held;
    rep_push   = 1'b0;
    if (!repeat_en) begin
      rep_next = R_IDLE;
    end else if (ext_push) begin
      held_next.vec274 = evt_vec274;
      held_next.code   = evt_code;
      timer_next       = DELAY_T;
      rep_next         = R_DELAY;
    end else if (is_break_held) begin
      rep_next = R_IDLE;
    end else if (rep_state != R_IDLE && tick) begin
      if (timer == 16'd1) begin
        rep_push   = fifo_empty;
        timer_next = RATE_T;
        rep_next   = R_REPEAT;
      end else begin
        timer_next = timer - 16'd1;
      end
    end
  end

  always_ff @(posedge clk_bus or negedge reset_n) begin
    if (!reset_n) begin
      rep_state <= R_IDLE;
      timer     <= '0;
      held      <= '0;
    end else if (flush) begin
      rep_state <= R_IDLE;
      timer     <= '0;
      held      <= '0;
    end else begin
      rep_state <= rep_next;
      timer     <= timer_next;
      held      <= held_next;
    end
  end

  always_comb begin
    dlv_next   = dlv_state;
    wait_next  = wait_cnt;
    kreg_load  = 1'b0;
    fifo_pop   = 1'b0;
    latch_head = 1'b0;
    case (dlv_state)
      D_IDLE: begin
        if (!fifo_empty && !kreg_busy) begin
          dlv_next   = D_LOAD;
          latch_head = 1'b1;
        end
      end
      D_LOAD: begin
        kreg_load = 1'b1;
        fifo_pop  = 1'b1;
        wait_next = '0;
        dlv_next  = D_WAIT;
      end
      D_WAIT: begin
        if (kreg_busy || wait_cnt == WAIT_LAST) dlv_next = D_IDLE;
        else                                    wait_next = wait_cnt + WCW'(1);
      end
      default: dlv_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk_bus or negedge reset_n) begin
    if (!reset_n) begin
      dlv_state <= D_IDLE;
      wait_cnt  <= '0;
    end else if (flush) begin
      dlv_state <= D_IDLE;
      wait_cnt  <= '0;
    end else begin
      dlv_state <= dlv_next;
      wait_cnt  <= wait_next;
    end
  end

  // The code is captured one cycle ahead so it is already valid while
  // kreg_load is high, and holds until the next load.
  always_ff @(posedge clk_bus or negedge reset_n) begin
    if (!reset_n) begin
      kreg_code   <= '0;
      kreg_vec274 <= 1'b0;
    end else if (latch_head && !flush) begin
      kreg_code   <= fifo_head.code;
      kreg_vec274 <= fifo_head.vec274;
    end
  end

endmodule

// File: tb/tb_kbd_key_sched.sv
// Bench for kbd_key_sched: directed scenarios plus random traffic, checked by
// a queue-level reference model and a load scoreboard.
module tb_kbd_key_sched;
  import kbd_pkg::*;

  localparam int DEPTH     = 8;
  localparam int TICK_DIV  = 4;
  localparam int REP_DELAY = 3;
  localparam int REP_RATE  = 2;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic          clk_bus    = 1'b0;
  logic          reset_n    = 1'b0;
  logic          flush      = 1'b0;
  logic          evt_valid  = 1'b0;
  logic          evt_press  = 1'b0;
  logic [6:0]    evt_code   = '0;
  logic          evt_vec274 = 1'b0;
  logic          evt_ready;
  logic          repeat_en  = 1'b0;
  logic          kreg_busy  = 1'b0;
  logic          kreg_load;
  logic [6:0]    kreg_code;
  logic          kreg_vec274;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  kbd_dbg_t      dbg;

  kbd_key_sched #(
    .DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)
  ) dut (
    .clk_bus(clk_bus), .reset_n(reset_n), .flush(flush),
    .evt_valid(evt_valid), .evt_press(evt_press), .evt_code(evt_code),
    .evt_vec274(evt_vec274), .evt_ready(evt_ready), .repeat_en(repeat_en),
    .kreg_busy(kreg_busy), .kreg_load(kreg_load), .kreg_code(kreg_code),
    .kreg_vec274(kreg_vec274), .fifo_count(fifo_count), .overflow(overflow),
    .dbg(dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_bus = ~clk_bus;

  int cyc = 0;
  always @(posedge clk_bus) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] load_log[$];
  int         load_cyc[$];
  int         n_loads  = 0;
  logic [7:0] mon_e;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Queue of pending codes, a tick count since the last clear, the held key
  // with ticks remaining, and the delivery pacing.
  logic [7:0] m_q[$];
  bit         m_ovf       = 0;
  int         m_cyc       = 0;
  bit         m_held_on   = 0;
  logic [7:0] m_held      = '0;
  int         m_ticks     = 0;
  bit         m_load_now  = 0;
  int         m_wait_left = 0;
  bit         m_full, m_empty, m_tick, m_press, m_push, m_rep;

  task automatic model_clear();
    m_q.delete();
    m_ovf       = 0;
    m_cyc       = 0;
    m_held_on   = 0;
    m_held      = '0;
    m_ticks     = 0;
    m_load_now  = 0;
    m_wait_left = 0;
  endtask

  always @(posedge clk_bus or negedge reset_n) begin
    if (!reset_n) begin
      model_clear();
      exp_q.delete();
    end else if (flush) begin
      model_clear();
    end else begin
      m_full  = (m_q.size() == DEPTH);
      m_empty = (m_q.size() == 0);
      m_tick  = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
      m_cyc++;
      m_press = evt_valid && evt_press && (evt_code != 7'd0);
      m_push  = m_press && !m_full;
      m_rep   = 0;
      if (m_press && m_full) m_ovf = 1;
      if (!repeat_en) m_held_on = 0;
      else if (m_push) begin
        m_held    = {evt_vec274, evt_code};
        m_held_on = 1;
        m_ticks   = REP_DELAY;
      end else if (evt_valid && !evt_press && evt_code == m_held[6:0]) m_held_on = 0;
      else if (m_held_on && m_tick) begin
        m_ticks--;
        if (m_ticks == 0) begin
          m_rep   = m_empty;
          m_ticks = REP_RATE;
        end
      end
      if (m_load_now) begin
        void'(m_q.pop_front());
        m_load_now  = 0;
        m_wait_left = WAIT_LIMIT;
      end else if (m_wait_left > 0) begin
        if (kreg_busy || m_wait_left == 1) m_wait_left = 0;
        else m_wait_left--;
      end else if (!m_empty && !kreg_busy) begin
        m_load_now = 1;
        exp_q.push_back(m_q[0]);
      end
      if (m_push) m_q.push_back({evt_vec274, evt_code});
      else if (m_rep) m_q.push_back(m_held);
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk_bus);
    if (reset_n) begin
      check("load_timing", int'(kreg_load), int'(m_load_now));
      check("fifo_count", int'(fifo_count), m_q.size());
      check("evt_ready", int'(evt_ready), int'(m_q.size() != DEPTH));
      check("overflow", int'(overflow), int'(m_ovf));
      if (kreg_load) begin
        n_loads++;
        load_log.push_back({kreg_vec274, kreg_code});
        load_cyc.push_back(cyc);
        check("load_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("kreg_data", int'({kreg_vec274, kreg_code}), int'(mon_e));
        end
      end
    end
  end

  // ---------------- CPU side of 177660/177662 ----------------
  int cpu_mode   = 0;  // 0 responds, 1 holds busy, 2 never sets busy
  int cpu_lat    = 2;
  bit cpu_random = 0;
  int busy_left  = 0;

  initial forever begin
    @(negedge clk_bus);
    case (cpu_mode)
      1: begin kreg_busy = 1'b1; busy_left = 0; end
      2: begin kreg_busy = 1'b0; busy_left = 0; end
      default: begin
        if (kreg_busy) begin
          if (busy_left <= 1) begin kreg_busy = 1'b0; busy_left = 0; end
          else busy_left--;
        end else if (kreg_load && reset_n) begin
          if (!cpu_random || $urandom_range(0, 7) != 0) begin
            kreg_busy = 1'b1;
            busy_left = cpu_random ? int'($urandom_range(1, 8)) : cpu_lat;
          end
        end
      end
    endcase
  end

  // ---------------- drivers ----------------
  task automatic step(int n);
    repeat (n) @(posedge clk_bus);
    #2;
  endtask

  task automatic send(bit press, logic [6:0] code, bit vec);
    evt_valid  = 1'b1;
    evt_press  = press;
    evt_code   = code;
    evt_vec274 = vec;
    step(1);
    evt_valid  = 1'b0;
    evt_press  = 1'b0;
    evt_code   = '0;
    evt_vec274 = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
  endtask

  task automatic run_random(int n);
    int         r;
    logic [6:0] c;
    logic [6:0] last_code;
    last_code = 7'h41;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40) begin
        c = ($urandom_range(0, 15) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
        last_code = c;
        send(1'b1, c, 1'($urandom_range(0, 1)));
      end else if (r < 60) begin
        c = ($urandom_range(0, 1) == 1) ? last_code : 7'($urandom_range(0, 127));
        send(1'b0, c, 1'b0);
      end else if (r < 62) begin
        pulse_flush();
      end else if (r < 66) begin
        repeat_en = ~repeat_en;
      end else begin
        step(1);
      end
      step(int'($urandom_range(0, 3)));
    end
  endtask

  // ---------------- stimulus ----------------
  int base;
  int idx;

  initial begin
    #3;
    check("rst_kreg_load", int'(kreg_load), 0);
    check("rst_kreg_code", int'(kreg_code), 0);
    check("rst_kreg_vec", int'(kreg_vec274), 0);
    check("rst_evt_ready", int'(evt_ready), 1);
    check("rst_fifo_count", int'(fifo_count), 0);
    check("rst_overflow", int'(overflow), 0);
    step(3);
    reset_n = 1'b1;
    step(3);

    // Single press, idle register: load two cycles after the press.
    send(1'b1, 7'h41, 1'b0);
    check("a_count_n1", int'(fifo_count), 1);
    check("a_load_n1", int'(kreg_load), 0);
    step(1);
    check("a_load_n2", int'(kreg_load), 1);
    check("a_code", int'(kreg_code), 'h41);
    check("a_vec", int'(kreg_vec274), 0);
    send(1'b0, 7'h41, 1'b0);
    step(8);
    check("a_count_drain", int'(fifo_count), 0);

    // Register busy: nine presses, the ninth is dropped.
    cpu_mode = 1;
    step(2);
    for (int i = 1; i <= 9; i++) send(1'b1, 7'(i), 1'b0);
    check("b_count_full", int'(fifo_count), DEPTH);
    check("b_ready_low", int'(evt_ready), 0);
    check("b_overflow", int'(overflow), 1);
    idx = load_log.size();
    cpu_mode = 0;
    step(80);
    check("b_loads", load_log.size() - idx, 8);
    for (int i = 0; i < 8 && idx + i < load_log.size(); i++)
      check("b_order", int'(load_log[idx + i]), i + 1);

    // Typematic repeat of a held key.
    repeat_en = 1'b1;
    idx = load_log.size();
    send(1'b1, 7'h42, 1'b0);
    step(70);
    send(1'b0, 7'h42, 1'b0);
    step(10);
    check("c_enough_loads", int'(load_log.size() - idx >= 6), 1);
    for (int j = idx; j < load_log.size(); j++) check("c_code", int'(load_log[j]), 'h42);
    if (load_log.size() > idx + 1) begin
      check("c_first_min", int'(load_cyc[idx + 1] - load_cyc[idx] >= (REP_DELAY - 1) * TICK_DIV + 1), 1);
      check("c_first_max", int'(load_cyc[idx + 1] - load_cyc[idx] <= REP_DELAY * TICK_DIV), 1);
    end
    for (int j = idx + 2; j < load_cyc.size(); j++)
      check("c_interval", load_cyc[j] - load_cyc[j - 1], REP_RATE * TICK_DIV);
    base = n_loads;
    step(40);
    check("c_stop", n_loads - base, 0);

    // Second key takes over the repeat; releasing the first does not stop it.
    send(1'b1, 7'h43, 1'b0);
    step(30);
    send(1'b1, 7'h44, 1'b0);
    step(30);
    send(1'b0, 7'h43, 1'b0);
    idx = load_log.size();
    step(30);
    check("d_continue", int'(load_log.size() - idx >= 2), 1);
    for (int j = idx; j < load_log.size(); j++) check("d_code", int'(load_log[j]), 'h44);
    send(1'b0, 7'h44, 1'b0);
    step(10);
    base = n_loads;
    step(40);
    check("d_stop", n_loads - base, 0);

    // Repeat disabled: one load only. Code 0 never queued.
    repeat_en = 1'b0;
    base = n_loads;
    send(1'b1, 7'h45, 1'b0);
    step(60);
    check("e_single_load", n_loads - base, 1);
    send(1'b0, 7'h45, 1'b0);
    base = n_loads;
    send(1'b1, 7'h00, 1'b0);
    check("e_zero_count", int'(fifo_count), 0);
    step(10);
    check("e_zero_noload", n_loads - base, 0);

    // Flush with entries queued while waiting on an unresponsive register.
    cpu_mode = 2;
    step(2);
    for (int i = 0; i < 4; i++) send(1'b1, 7'(8'h51 + i), 1'b0);
    check("f_count_3", int'(fifo_count), 3);
    check("f_in_wait", int'(dbg.dlv), int'(D_WAIT));
    base = n_loads;
    pulse_flush();
    check("f_count_0", int'(fifo_count), 0);
    check("f_overflow_0", int'(overflow), 0);
    step(30);
    check("f_no_load", n_loads - base, 0);
    cpu_mode = 0;

    // Random traffic against the model.
    cpu_random = 1;
    run_random(1200);

    // Asynchronous reset in the middle of activity.
    repeat_en = 1'b1;
    for (int i = 0; i < 5; i++) send(1'b1, 7'(8'h61 + i), 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check("ar_kreg_load", int'(kreg_load), 0);
    check("ar_kreg_code", int'(kreg_code), 0);
    check("ar_kreg_vec", int'(kreg_vec274), 0);
    check("ar_evt_ready", int'(evt_ready), 1);
    check("ar_fifo_count", int'(fifo_count), 0);
    check("ar_overflow", int'(overflow), 0);
    step(2);
    reset_n = 1'b1;
    run_random(60);

    repeat_en  = 1'b0;
    cpu_random = 0;
    cpu_mode   = 0;
    step(150);
    check("drain_exp_q", exp_q.size(), 0);
    check("drain_count", int'(fifo_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
